// File: rtl/blood_test_scheduler_if.sv
// Request/result bundle between the bedside sample sources and the shared-detector scheduler.
// Handshake: a sample on channel i transfers at the rising edge where reqValid[i] & reqReady[i];
// the source holds its sample stable until then, and resValid pulses once per captured result.
interface blood_test_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]   reqValid;
    logic [4*NUM_CH-1:0] reqPH;
    logic [3*NUM_CH-1:0] reqType;
    logic [NUM_CH-1:0]   reqReady;
    logic                resValid;
    logic [CH_W-1:0]     resChannel;
    logic                resAbnormal;

    modport master (
        output reqValid, reqPH, reqType,
        input  reqReady, resValid, resChannel, resAbnormal
    );

    modport slave (
        input  reqValid, reqPH, reqType,
        output reqReady, resValid, resChannel, resAbnormal
    );
endinterface

// File: rtl/blood_test_scheduler.sv
// Round-robin scheduler sharing one combinational blood abnormality detector among NUM_CH
// channels; holds detector inputs for a settle window, reports the result, counts abnormals.
module blood_test_scheduler #(
    parameter int NUM_CH        = 4,
    parameter int CH_W          = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    blood_test_scheduler_if.slave       req,
    output logic [3:0]                  detPH,
    output logic [2:0]                  detType,
    input  logic                        detAbnormality,
    input  logic                        countClear,
    output logic [NUM_CH*CNT_WIDTH-1:0] abnormalCount,
    output logic                        busy,
    output logic [1:0]                  dbgState
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]            det_ph_q, det_ph_d;
    logic [2:0]            det_type_q, det_type_d;
    logic [CH_W-1:0]       res_ch_q, res_ch_d;
    logic                  res_abn_q, res_abn_d;
    logic                  res_valid_q, res_valid_d;
    logic [SC_W-1:0]       settle_q, settle_d;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];

    logic                  grant_any;
    logic [CH_W-1:0]       grant_idx;
    logic [NUM_CH-1:0]     grant_oh;
    logic [3:0]            sel_ph;
    logic [2:0]            sel_type;
    logic                  capture;

    // First asserted request after the last granted channel, wrapping modulo NUM_CH.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] valid,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] sel;
        logic [CH_W-1:0] cand;
        logic            hit;
        int              idx;
        sel = '0;
        hit = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx  = (int'(ptr) + k) % NUM_CH;
            cand = CH_W'(idx);
            if (!hit && valid[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        return sel;
    endfunction

    always_comb begin
        grant_any = (state_q == IDLE) && (|req.reqValid);
        grant_idx = rr_pick(req.reqValid, rr_ptr_q);
        grant_oh  = '0;
        if (grant_any) grant_oh[grant_idx] = 1'b1;
        sel_ph   = '0;
        sel_type = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CH_W'(i)) begin
                sel_ph   = req.reqPH[4*i +: 4];
                sel_type = req.reqType[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        det_ph_d    = det_ph_q;
        det_type_d  = det_type_q;
        res_ch_d    = res_ch_q;
        res_abn_d   = res_abn_q;
        res_valid_d = 1'b0;
        settle_d    = settle_q;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    det_ph_d   = sel_ph;
                    det_type_d = sel_type;
                    res_ch_d   = grant_idx;
                    rr_ptr_d   = grant_idx;
                    settle_d   = SETTLE_LOAD;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    capture     = 1'b1;
                    res_abn_d   = detAbnormality;
                    res_valid_d = 1'b1;
                    state_d     = REPORT;
                end else begin
                    settle_d = settle_q - SC_W'(1);
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear beats a same-cycle increment; counters stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (countClear) begin
                cnt_d[i] = '0;
            end else if (capture && detAbnormality && (res_ch_q == CH_W'(i))
                         && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            det_ph_q    <= '0;
            det_type_q  <= '0;
            res_ch_q    <= '0;
            res_abn_q   <= 1'b0;
            res_valid_q <= 1'b0;
            settle_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            det_ph_q    <= det_ph_d;
            det_type_q  <= det_type_d;
            res_ch_q    <= res_ch_d;
            res_abn_q   <= res_abn_d;
            res_valid_q <= res_valid_d;
            settle_q    <= settle_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign abnormalCount[CNT_WIDTH*g +: CNT_WIDTH] = cnt_q[g];
    end

    assign req.reqReady    = grant_oh;
    assign req.resValid    = res_valid_q;
    assign req.resChannel  = res_ch_q;
    assign req.resAbnormal = res_abn_q;
    assign detPH           = det_ph_q;
    assign detType         = det_type_q;
    assign busy            = (state_q != IDLE);
    assign dbgState        = state_q;

endmodule

// File: tb/tb_blood_test_scheduler.sv
// Two schedulers (8-bit and 2-bit counters) run in lockstep on shared random/directed stimulus
// and are compared every cycle against a cycle-level reference of the round-robin schedule.
module tb_blood_test_scheduler;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int SETTLE = 2;
  localparam int EW     = 32 + CH_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic count_clear;
  always #5 clk = ~clk;

  blood_test_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus8 ();
  blood_test_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus2 ();

  logic [3:0]  det_ph8, det_ph2;
  logic [2:0]  det_ty8, det_ty2;
  logic        det_abn8, det_abn2;
  logic [31:0] cnt8;
  logic [7:0]  cnt2;
  logic        busy8, busy2;
  logic [1:0]  dbg8, dbg2;

  assign det_abn8 = (det_ph8 == 4'b0111);
  assign det_abn2 = (det_ph2 == 4'b0111);
  assign bus2.reqValid = bus8.reqValid;
  assign bus2.reqPH    = bus8.reqPH;
  assign bus2.reqType  = bus8.reqType;

  blood_test_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .req(bus8), .detPH(det_ph8), .detType(det_ty8),
    .detAbnormality(det_abn8), .countClear(count_clear), .abnormalCount(cnt8),
    .busy(busy8), .dbgState(dbg8)
  );

  blood_test_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYCLES(SETTLE), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .req(bus2), .detPH(det_ph2), .detType(det_ty2),
    .detAbnormality(det_abn2), .countClear(count_clear), .abnormalCount(cnt2),
    .busy(busy2), .dbgState(dbg2)
  );

  // reference model state
  int              cyc;
  int              next_free;
  int              last_g;
  logic [3:0]      m_ph;
  logic [2:0]      m_ty;
  logic [CH_W-1:0] m_ch;
  logic            m_abn;
  int              m_cnt8 [NUM_CH];
  int              m_cnt2 [NUM_CH];
  logic [EW-1:0]   exp_q[$];

  // sample sources
  logic            s_valid [NUM_CH];
  logic [3:0]      s_ph    [NUM_CH];
  logic [2:0]      s_ty    [NUM_CH];
  int              s_left  [NUM_CH];
  bit              rand_mode;
  bit              clr_on_capture;

  int total;
  int bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int rr_pick();
    for (int k = 1; k <= NUM_CH; k++) begin
      int idx;
      idx = (last_g + k) % NUM_CH;
      if (s_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic load_src(input int ch, input int n, input logic [3:0] ph, input logic [2:0] ty);
    s_left[ch] = n;
    s_ph[ch]   = ph;
    s_ty[ch]   = ty;
  endtask

  task automatic refill();
    for (int i = 0; i < NUM_CH; i++) begin
      if (!s_valid[i]) begin
        if (s_left[i] > 0) begin
          s_valid[i] = 1'b1;
        end else if (rand_mode && $urandom_range(0, 3) == 0) begin
          s_valid[i] = 1'b1;
          s_ph[i]    = ($urandom_range(0, 1) == 1) ? 4'd7 : 4'($urandom_range(0, 15));
          s_ty[i]    = 3'($urandom_range(0, 7));
        end
      end
    end
  endtask

  task automatic model_reset();
    next_free = cyc + 1;
    last_g    = NUM_CH - 1;
    m_ph      = '0;
    m_ty      = '0;
    m_ch      = '0;
    m_abn     = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt8[i] = 0;
      m_cnt2[i] = 0;
    end
  endtask

  // driver: one clock cycle of stimulus, per-cycle checks, then model update for the edge
  task automatic one_cycle(input bit do_rst, input bit do_clr);
    int              g;
    logic [NUM_CH-1:0] exp_ready;
    logic            exp_rv;
    logic [EW-1:0]   e;
    logic [31:0]     e8;
    logic [7:0]      e2;
    @(posedge clk);
    #1;
    refill();
    if (clr_on_capture && exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc + 1) do_clr = 1'b1;
    rst         = do_rst;
    count_clear = do_clr;
    for (int i = 0; i < NUM_CH; i++) begin
      bus8.reqValid[i]       = s_valid[i];
      bus8.reqPH[4*i +: 4]   = s_ph[i];
      bus8.reqType[3*i +: 3] = s_ty[i];
    end
    @(negedge clk);

    g = (cyc >= next_free) ? rr_pick() : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    exp_rv = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) == cyc);
    if (exp_rv) begin
      e     = exp_q.pop_front();
      m_ch  = e[CH_W:1];
      m_abn = e[0];
    end
    e8 = '0;
    e2 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      e8[8*i +: 8] = 8'(m_cnt8[i]);
      e2[2*i +: 2] = 2'(m_cnt2[i]);
    end
    check("req_ready8", 64'(bus8.reqReady), 64'(exp_ready));
    check("req_ready2", 64'(bus2.reqReady), 64'(exp_ready));
    check("res_valid8", 64'(bus8.resValid), 64'(exp_rv));
    check("res_valid2", 64'(bus2.resValid), 64'(exp_rv));
    if (exp_rv) begin
      check("res_channel8", 64'(bus8.resChannel), 64'(m_ch));
      check("res_channel2", 64'(bus2.resChannel), 64'(m_ch));
    end
    check("res_abnormal", 64'(bus8.resAbnormal), 64'(m_abn));
    check("det_ph", 64'(det_ph8), 64'(m_ph));
    check("det_type", 64'(det_ty8), 64'(m_ty));
    check("det_ph2", 64'(det_ph2), 64'(m_ph));
    check("busy8", 64'(busy8), 64'(cyc < next_free));
    check("busy2", 64'(busy2), 64'(cyc < next_free));
    check("dbg_state_busy", 64'(dbg8 != 2'd0), 64'(cyc < next_free));
    check("count8", 64'(cnt8), 64'(e8));
    check("count2", 64'(cnt2), 64'(e2));

    if (do_rst) begin
      model_reset();
    end else begin
      if (do_clr) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_cnt8[i] = 0;
          m_cnt2[i] = 0;
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc + 1 && exp_q[0][0]) begin
        m_cnt8[exp_q[0][CH_W:1]] = (m_cnt8[exp_q[0][CH_W:1]] < 255) ? m_cnt8[exp_q[0][CH_W:1]] + 1 : 255;
        m_cnt2[exp_q[0][CH_W:1]] = (m_cnt2[exp_q[0][CH_W:1]] < 3) ? m_cnt2[exp_q[0][CH_W:1]] + 1 : 3;
      end
      if (g >= 0) begin
        exp_q.push_back({32'(cyc + SETTLE + 1), CH_W'(g), (s_ph[g] == 4'd7)});
        m_ph       = s_ph[g];
        m_ty       = s_ty[g];
        last_g     = g;
        next_free  = cyc + SETTLE + 2;
        s_valid[g] = 1'b0;
        if (s_left[g] > 0) s_left[g]--;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) one_cycle(1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rand_mode      = 1'b0;
    clr_on_capture = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      s_valid[i] = 1'b0;
      s_ph[i]    = '0;
      s_ty[i]    = '0;
      s_left[i]  = 0;
    end
    model_reset();
    next_free     = 0;
    rst           = 1'b1;
    count_clear   = 1'b0;
    bus8.reqValid = '0;
    bus8.reqPH    = '0;
    bus8.reqType  = '0;
    @(posedge clk);
    one_cycle(1'b1, 1'b0);
    one_cycle(1'b1, 1'b0);

    // single ch0 sample, normal pH
    load_src(0, 1, 4'b0010, 3'b000);
    run(8);

    // all four channels requesting continuously
    for (int i = 0; i < NUM_CH; i++) load_src(i, 2, 4'($urandom_range(0, 6)), 3'(i));
    run(36);

    // three abnormal samples on ch2
    load_src(2, 3, 4'b0111, 3'b010);
    run(16);

    // five abnormal samples on ch1 saturate the 2-bit counter
    load_src(1, 5, 4'b0111, 3'b001);
    run(22);

    // clear coinciding with an abnormal capture
    clr_on_capture = 1'b1;
    load_src(1, 1, 4'b0111, 3'b001);
    run(6);
    clr_on_capture = 1'b0;

    // reset while ch3 is settling, then ch0 and ch3 contend
    load_src(3, 1, 4'b0111, 3'b011);
    one_cycle(1'b0, 1'b0);
    one_cycle(1'b1, 1'b0);
    load_src(0, 1, 4'b0100, 3'b000);
    load_src(3, 1, 4'b0111, 3'b011);
    run(12);

    // ch1 arrives while ch0 is in flight
    load_src(0, 1, 4'b0111, 3'b101);
    one_cycle(1'b0, 1'b0);
    load_src(1, 1, 4'b0011, 3'b110);
    run(10);

    // randomized traffic with occasional mid-flight resets and clears
    rand_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      one_cycle((cyc < next_free) && ($urandom_range(0, 60) == 0), ($urandom_range(0, 80) == 0));
    end
    rand_mode = 1'b0;
    run(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blood_test_scheduler.md
Name: blood_test_scheduler

Overview:
Round-robin scheduler that shares one combinational BloodAbnormalityDetector among NUM_CH sample sources (bedside channels). It accepts one sample at a time over a valid/ready handshake and drives the detector's bloodPH and bloodType inputs. After a settle window it captures bloodAbnormality, reports the result tagged with the channel, and keeps a per-channel saturating abnormality count.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, channel index width, must equal ceil(log2(NUM_CH))
SETTLE_CYCLES, 2, cycles the detector inputs are held before capture (>=1)
CNT_WIDTH, 8, width of each per-channel abnormality counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
reqValid  in  NUM_CH  per-channel sample request
reqPH  in  4*NUM_CH  per-channel pH code; channel i in bits [4i+3:4i]
reqType  in  3*NUM_CH  per-channel blood type code; channel i in bits [3i+2:3i]
reqReady  out  NUM_CH  one-hot grant; transfer when reqValid[i] & reqReady[i] at clk edge
detPH  out  4  to detector bloodPH
detType  out  3  to detector bloodType
detAbnormality  in  1  from detector bloodAbnormality
resValid  out  1  result strobe, high exactly 1 cycle per sample
resChannel  out  CH_W  channel of current result
resAbnormal  out  1  captured detector output
countClear  in  1  synchronous clear of all counters
abnormalCount  out  NUM_CH*CNT_WIDTH  per-channel count; channel i in bits [CNT_WIDTH*(i+1)-1:CNT_WIDTH*i]
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, SETTLE, REPORT.
- Reset values: state IDLE; rrPtr = NUM_CH-1, so channel 0 has first priority; detPH=0; detType=0; resValid=0; resChannel=0; resAbnormal=0; all counters 0; busy=0.
- reqReady is combinational. It is nonzero only in IDLE and is then the one-hot grant of the first asserted reqValid searching rrPtr+1, rrPtr+2, ... with wrap modulo NUM_CH. reqReady is all zeros outside IDLE and all zeros when no request is present.
- IDLE, on the edge with a grant g:
  - latch reqPH/reqType slice g into detPH/detType.
  - latch g into resChannel and rrPtr.
  - load settle counter with SETTLE_CYCLES-1.
  - go to SETTLE.
- SETTLE: the settle counter decrements each cycle. On the edge where it equals 0:
  - resAbnormal <= detAbnormality.
  - resValid <= 1.
  - if detAbnormality is 1, increment counter[resChannel].
  - go to REPORT.
- REPORT: resValid=1 for this single cycle, then IDLE with resValid <= 0.
- Latency: accept edge to resValid high = SETTLE_CYCLES+1 cycles. Minimum spacing between accepts = SETTLE_CYCLES+2 cycles.
- Output hold: detPH/detType hold the last accepted sample until the next accept. resChannel/resAbnormal hold until the next capture.
- A requester's sample is not consumed until it sees reqReady. Ungranted requests wait with no loss. Requests are not queued internally.
- Counters saturate at 2^CNT_WIDTH-1; no wrap.
- countClear clears all counters. When countClear coincides with an increment, clear wins and the counter ends at 0. countClear does not affect the FSM.
- Reset mid-operation (SETTLE or REPORT): return to IDLE next cycle, drop the in-flight sample, emit no resValid, restore all reset values.
- reqValid changes outside IDLE are ignored. Arbitration is evaluated only in IDLE.

Test Plan:
- Reset then a single request: ch0 reqValid, reqPH=4'b0010, reqType=3'b000, detector stub detAbnormality=(detPH==4'b0111). Required: reqReady=4'b0001 in cycle 0; detPH=2 from cycle 1; resValid high in cycle 3 only with resChannel=0, resAbnormal=0; count0 stays 0.
- All four channels hold reqValid continuously. Required: grants in order ch0, ch1, ch2, ch3, ch0, one every 4 cycles; reqReady is never multi-hot.
- ch2 with reqPH=4'b0111, reqType=3'b010, repeated 3 times. Required: resAbnormal=1 each time; abnormalCount ch2 field = 3; other fields = 0.
- CNT_WIDTH=2: 5 abnormal samples on ch1. Required: count1 saturates at 3. Then countClear asserted in the same cycle as an abnormal capture: count1 = 0.
- rst asserted during SETTLE after ch3 is accepted. Required: no resValid pulse; next grant goes to ch0 with ch0 and ch3 both requesting (rrPtr reset).
- Back-to-back requests: ch1 requests while busy with ch0. Required: reqReady=0 until IDLE; ch1 is accepted exactly 4 cycles after the ch0 accept (SETTLE_CYCLES=2).
